round_mix_ctrl: RTL and testbench

Round sequencer and mixing stage directly downstream of the S-box lookup stage. Accepts a 32-bit plaintext word and applies key whitening. It then issues the word to the S-box stage, takes the four substituted bytes back, and applies byte rotation plus round-key XOR. It feeds the result back for the next round and presents the final ciphertext after `ROUNDS` rounds, driving a done strobe.

---
 rtl/round_mix_ctrl_if.sv | 31 +++
 rtl/round_mix_ctrl.sv | 103 ++++++++++
 tb/tb_round_mix_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/round_mix_ctrl_if.sv
// Handshake and data bundle between the round mixer, the S-box stage and the key stage.
// The master side drives the requests and keys, and the slave side (the mixer) drives the results.
interface round_mix_ctrl_if;
  logic        GLOBAL_EN;
  logic        START;
  logic [31:0] PLAIN_IN;
  logic [7:0]  OUT_1;
  logic [7:0]  OUT_2;
  logic [7:0]  OUT_3;
  logic [7:0]  OUT_4;
  logic        EN;
  logic [7:0]  K_1;
  logic [7:0]  K_2;
  logic [7:0]  K_3;
  logic [31:0] FEED_WORD;
  logic        FEED_VALID;
  logic [31:0] CIPHER_OUT;
  logic        DONE;
  logic        BUSY;
  logic [3:0]  ROUND_CNT;

  modport master (
    output GLOBAL_EN, START, PLAIN_IN, OUT_1, OUT_2, OUT_3, OUT_4, EN, K_1, K_2, K_3,
    input  FEED_WORD, FEED_VALID, CIPHER_OUT, DONE, BUSY, ROUND_CNT
  );

  modport slave (
    input  GLOBAL_EN, START, PLAIN_IN, OUT_1, OUT_2, OUT_3, OUT_4, EN, K_1, K_2, K_3,
    output FEED_WORD, FEED_VALID, CIPHER_OUT, DONE, BUSY, ROUND_CNT
  );
endinterface

// File: rtl/round_mix_ctrl.sv
// Round sequencer: whitens the plaintext, loops it through the S-box stage ROUNDS times and mixes each result.
// Latency is ROUNDS*(2 + S-box latency) cycles from START to DONE. There is no queuing: START while busy is dropped, and GLOBAL_EN low aborts.
module round_mix_ctrl #(
  parameter int unsigned ROUNDS     = 4,
  parameter logic [7:0]  KEY4_CONST = 8'h5A
) (
  input logic             CLK,
  input logic             RST,
  round_mix_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] feed_word_q;
  logic        feed_valid_q;
  logic [31:0] cipher_out_q;
  logic        done_q;
  logic        busy_q;
  logic [3:0]  round_cnt_q;

  logic [7:0]  key4;
  logic [31:0] round_key;
  logic [31:0] rotated;
  logic [31:0] mixed;
  logic        last_round;

  assign key4       = bus.K_1 ^ bus.K_2 ^ bus.K_3 ^ KEY4_CONST;
  assign round_key  = {bus.K_1, bus.K_2, bus.K_3, key4};
  assign rotated    = {bus.OUT_2, bus.OUT_3, bus.OUT_4, bus.OUT_1};
  assign mixed      = rotated ^ round_key ^ {28'b0, round_cnt_q};
  assign last_round = (round_cnt_q == 4'(ROUNDS - 1));

  // Strobes are set on the edge entering ISSUE/FINISH so they are high for exactly that state's cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      feed_word_q  <= '0;
      feed_valid_q <= 1'b0;
      cipher_out_q <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      round_cnt_q  <= '0;
    end else begin
      feed_valid_q <= 1'b0;
      done_q       <= 1'b0;
      if (!bus.GLOBAL_EN) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.START) begin
              feed_word_q  <= bus.PLAIN_IN ^ round_key;
              round_cnt_q  <= '0;
              feed_valid_q <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= ISSUE;
            end
          end
          ISSUE: begin
            state_q <= WAIT;
          end
          WAIT: begin
            if (bus.EN) begin
              if (last_round) begin
                cipher_out_q <= mixed;
                done_q       <= 1'b1;
                state_q      <= FINISH;
              end else begin
                feed_word_q  <= mixed;
                round_cnt_q  <= round_cnt_q + 4'd1;
                feed_valid_q <= 1'b1;
                state_q      <= ISSUE;
              end
            end
          end
          FINISH: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.FEED_WORD  = feed_word_q;
  assign bus.FEED_VALID = feed_valid_q;
  assign bus.CIPHER_OUT = cipher_out_q;
  assign bus.DONE       = done_q;
  assign bus.BUSY       = busy_q;
  assign bus.ROUND_CNT  = round_cnt_q;

endmodule

// File: tb/tb_round_mix_ctrl.sv
// Directed bench for round_mix_ctrl: three instances (ROUNDS = 1, 2, 4) share one clock and reset.
module tb_round_mix_ctrl;
  logic CLK;
  logic RST;
  int   total;
  int   bad;

  round_mix_ctrl_if if1 ();
  round_mix_ctrl_if if2 ();
  round_mix_ctrl_if if4 ();

  round_mix_ctrl #(.ROUNDS(1), .KEY4_CONST(8'h5A)) dut1 (.CLK(CLK), .RST(RST), .bus(if1));
  round_mix_ctrl #(.ROUNDS(2), .KEY4_CONST(8'h5A)) dut2 (.CLK(CLK), .RST(RST), .bus(if2));
  round_mix_ctrl #(.ROUNDS(4), .KEY4_CONST(8'h5A)) dut4 (.CLK(CLK), .RST(RST), .bus(if4));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b1;
    if1.GLOBAL_EN = 0; if1.START = 0; if1.PLAIN_IN = 0; if1.EN = 0;
    if1.OUT_1 = 0; if1.OUT_2 = 0; if1.OUT_3 = 0; if1.OUT_4 = 0;
    if1.K_1 = 0; if1.K_2 = 0; if1.K_3 = 0;
    if2.GLOBAL_EN = 0; if2.START = 0; if2.PLAIN_IN = 0; if2.EN = 0;
    if2.OUT_1 = 0; if2.OUT_2 = 0; if2.OUT_3 = 0; if2.OUT_4 = 0;
    if2.K_1 = 0; if2.K_2 = 0; if2.K_3 = 0;
    if4.GLOBAL_EN = 0; if4.START = 0; if4.PLAIN_IN = 0; if4.EN = 0;
    if4.OUT_1 = 0; if4.OUT_2 = 0; if4.OUT_3 = 0; if4.OUT_4 = 0;
    if4.K_1 = 0; if4.K_2 = 0; if4.K_3 = 0;
    step();
    step();
    check("rst_feed_word", if4.FEED_WORD, 32'h0);
    check("rst_feed_valid", 32'(if4.FEED_VALID), 32'h0);
    check("rst_cipher", if4.CIPHER_OUT, 32'h0);
    check("rst_done", 32'(if4.DONE), 32'h0);
    check("rst_busy", 32'(if4.BUSY), 32'h0);
    check("rst_round_cnt", 32'(if4.ROUND_CNT), 32'h0);
    RST = 1'b0;
    step();
    check("idle_after_release", 32'(if1.FEED_VALID), 32'h0);

    // Whitening, ROUNDS=1: K = AA550FAA, AAAAAAAA ^ K = 00FFA500
    if1.GLOBAL_EN = 1; if1.K_1 = 8'hAA; if1.K_2 = 8'h55; if1.K_3 = 8'h0F;
    if1.PLAIN_IN = 32'hAAAAAAAA; if1.START = 1;
    step();
    if1.START = 0;
    check("whiten_feed_valid", 32'(if1.FEED_VALID), 32'h1);
    check("whiten_feed_word", if1.FEED_WORD, 32'h00FFA500);
    check("whiten_busy", 32'(if1.BUSY), 32'h1);
    step();
    check("wait_feed_valid_low", 32'(if1.FEED_VALID), 32'h0);
    if1.EN = 1;
    step();
    if1.EN = 0;
    check("r1_zero_done", 32'(if1.DONE), 32'h1);
    check("r1_zero_cipher", if1.CIPHER_OUT, 32'hAA550FAA);
    step();
    check("r1_zero_done_low", 32'(if1.DONE), 32'h0);
    check("r1_zero_busy_low", 32'(if1.BUSY), 32'h0);

    // Single round with zero keys (K = 0000005A); a stale EN during ISSUE must be dropped
    if1.K_1 = 0; if1.K_2 = 0; if1.K_3 = 0; if1.PLAIN_IN = 32'h0; if1.START = 1;
    step();
    if1.START = 0;
    if1.EN = 1; if1.OUT_1 = 8'hFF; if1.OUT_2 = 8'hEE; if1.OUT_3 = 8'hDD; if1.OUT_4 = 8'hCC;
    step();
    check("stale_en_done", 32'(if1.DONE), 32'h0);
    check("stale_en_busy", 32'(if1.BUSY), 32'h1);
    check("stale_en_cipher", if1.CIPHER_OUT, 32'hAA550FAA);
    if1.OUT_1 = 8'h11; if1.OUT_2 = 8'h22; if1.OUT_3 = 8'h33; if1.OUT_4 = 8'h44;
    step();
    if1.EN = 0;
    check("k0_done", 32'(if1.DONE), 32'h1);
    check("k0_cipher", if1.CIPHER_OUT, 32'h2233444B);
    step();
    check("k0_busy_low", 32'(if1.BUSY), 32'h0);
    check("k0_done_low", 32'(if1.DONE), 32'h0);

    // Round index mix, ROUNDS=2, K = AA550FAA, plaintext 0
    if2.GLOBAL_EN = 1; if2.K_1 = 8'hAA; if2.K_2 = 8'h55; if2.K_3 = 8'h0F;
    if2.PLAIN_IN = 32'h0; if2.START = 1;
    step();
    check("r2_first_feed", if2.FEED_WORD, 32'hAA550FAA);
    if2.PLAIN_IN = 32'h12345678;
    step();
    if2.START = 0;
    check("busy_start_feed", if2.FEED_WORD, 32'hAA550FAA);
    check("busy_start_cnt", 32'(if2.ROUND_CNT), 32'h0);
    if2.EN = 1;
    step();
    if2.EN = 0;
    check("r2_second_valid", 32'(if2.FEED_VALID), 32'h1);
    check("r2_second_feed", if2.FEED_WORD, 32'hAA550FAA);
    check("r2_second_cnt", 32'(if2.ROUND_CNT), 32'h1);
    step();
    if2.EN = 1;
    step();
    if2.EN = 0;
    check("r2_done", 32'(if2.DONE), 32'h1);
    check("r2_cipher", if2.CIPHER_OUT, 32'hAA550FAB);
    step();

    // Abort in WAIT of the second round of four, with EN on the same edge
    if4.GLOBAL_EN = 1; if4.PLAIN_IN = 32'h01020304; if4.START = 1;
    step();
    if4.START = 0;
    check("r4_whiten", if4.FEED_WORD, 32'h0102035E);
    step();
    if4.EN = 1;
    step();
    if4.EN = 0;
    check("r4_round1_feed", if4.FEED_WORD, 32'h0000005A);
    step();
    if4.EN = 1; if4.GLOBAL_EN = 0;
    step();
    if4.EN = 0;
    check("abort_busy", 32'(if4.BUSY), 32'h0);
    check("abort_done", 32'(if4.DONE), 32'h0);
    check("abort_feed_valid", 32'(if4.FEED_VALID), 32'h0);
    check("abort_feed_word", if4.FEED_WORD, 32'h0000005A);
    check("abort_cipher", if4.CIPHER_OUT, 32'h0);
    if4.GLOBAL_EN = 1; if4.PLAIN_IN = 32'h0; if4.START = 1;
    step();
    if4.START = 0;
    check("restart_valid", 32'(if4.FEED_VALID), 32'h1);
    check("restart_cnt", 32'(if4.ROUND_CNT), 32'h0);
    for (int r = 0; r < 4; r++) begin
      step();
      if4.EN = 1;
      step();
      if4.EN = 0;
    end
    check("r4_done", 32'(if4.DONE), 32'h1);
    check("r4_cipher", if4.CIPHER_OUT, 32'h00000059);
    check("r4_final_cnt", 32'(if4.ROUND_CNT), 32'h3);
    step();
    check("r4_idle_cnt_kept", 32'(if4.ROUND_CNT), 32'h3);

    // Reset in WAIT clears everything at once, and later EN pulses do nothing
    if4.START = 1;
    step();
    if4.START = 0;
    step();
    RST = 1'b1;
    #1;
    check("midrst_cipher", if4.CIPHER_OUT, 32'h0);
    check("midrst_feed_word", if4.FEED_WORD, 32'h0);
    check("midrst_busy", 32'(if4.BUSY), 32'h0);
    check("midrst_cnt", 32'(if4.ROUND_CNT), 32'h0);
    step();
    RST = 1'b0;
    if4.EN = 1;
    step();
    check("postrst_valid", 32'(if4.FEED_VALID), 32'h0);
    step();
    if4.EN = 0;
    check("postrst_done", 32'(if4.DONE), 32'h0);
    check("postrst_busy", 32'(if4.BUSY), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
